// File: rtl/lmac_pkg.sv
// Shared definitions for the fractional MAC pipeline: op encodings,
// default width constants and the saturating add/subtract helper.
package lmac_pkg;

    localparam int unsigned LMAC_W  = 16;
    localparam int unsigned LMAC_RW = 2 * LMAC_W;
    localparam int unsigned SAT_XW  = 64;

    // Largest positive / most negative Q(2W-1) result for the default width
    localparam logic [LMAC_RW-1:0] MAXP = {1'b0, {(LMAC_RW-1){1'b1}}};
    localparam logic [LMAC_RW-1:0] MINN = {1'b1, {(LMAC_RW-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_MAC  = 2'b01,
        OP_MSU  = 2'b10,
        OP_CLR  = 2'b11
    } lmac_op_e;

    // x +/- y clamped to a signed rw-bit range (rw < 64); returns {ovf, result}.
    // Operands must already be sign-extended to 64 bits.
    function automatic logic [SAT_XW:0] sat_add(
        input logic signed [SAT_XW-1:0] x,
        input logic signed [SAT_XW-1:0] y,
        input logic                     sub,
        input int unsigned              rw
    );
        logic signed [SAT_XW:0] s;
        logic signed [SAT_XW:0] hi;
        logic signed [SAT_XW:0] lo;
        s  = sub ? ({x[SAT_XW-1], x} - {y[SAT_XW-1], y})
                 : ({x[SAT_XW-1], x} + {y[SAT_XW-1], y});
        hi = (65'sd1 <<< (rw - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (rw - 1));
        if (s > hi) begin
            return {1'b1, hi[SAT_XW-1:0]};
        end else if (s < lo) begin
            return {1'b1, lo[SAT_XW-1:0]};
        end
        return {1'b0, s[SAT_XW-1:0]};
    endfunction

endpackage

// File: rtl/lmac_pipe_if.sv
// Operand/result bundle for lmac_pipe.
//   master: drives in_valid, in_ch, in_op, a, b, sticky_clr
//   slave : drives out_valid, out_ch, out, ovf, sticky_ovf
interface lmac_pipe_if #(
    parameter int unsigned W   = 16,
    parameter int unsigned NCH = 4
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             in_valid;
    logic [CHW-1:0]   in_ch;
    logic [1:0]       in_op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             sticky_clr;
    logic             out_valid;
    logic [CHW-1:0]   out_ch;
    logic [2*W-1:0]   out;
    logic             ovf;
    logic [NCH-1:0]   sticky_ovf;

    modport master (
        output in_valid, in_ch, in_op, a, b, sticky_clr,
        input  out_valid, out_ch, out, ovf, sticky_ovf
    );

    modport slave (
        input  in_valid, in_ch, in_op, a, b, sticky_clr,
        output out_valid, out_ch, out, ovf, sticky_ovf
    );
endinterface

// File: rtl/lmac_frac_mult_sat.sv
// Two-stage signed fractional multiplier: S1 forms the exact 2W product,
// S2 doubles it and saturates the single min x min case.
//   clk, reset         : clock, synchronous active-high reset
//   i_valid, i_sb      : op valid and side-band carried alongside
//   i_a, i_b           : signed Q(W-1) operands
//   o_valid, o_sb      : delayed valid and side-band
//   o_p, o_ovf         : Q(2W-1) product and multiply-saturation flag
module frac_mult_sat #(
    parameter int unsigned W   = 16,
    parameter int unsigned SBW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [SBW-1:0]   i_sb,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic             o_valid,
    output logic [SBW-1:0]   o_sb,
    output logic [2*W-1:0]   o_p,
    output logic             o_ovf
);
    localparam int unsigned RW = 2 * W;
    // Only (-1) x (-1) produces 2^(2W-2); doubling it would wrap negative
    localparam logic [RW-1:0] P_MINMIN = {2'b01, {(RW-2){1'b0}}};
    localparam logic [RW-1:0] P_MAX    = {1'b0, {(RW-1){1'b1}}};

    logic signed [RW-1:0] w_a_ext;
    logic signed [RW-1:0] w_b_ext;
    logic signed [RW-1:0] w_prod;

    logic             r_v1;
    logic [SBW-1:0]   r_sb1;
    logic [RW-1:0]    r_p1;
    logic             r_v2;
    logic [SBW-1:0]   r_sb2;
    logic [RW-1:0]    r_p2;
    logic             r_ovf2;

    assign w_a_ext = {{W{i_a[W-1]}}, i_a};
    assign w_b_ext = {{W{i_b[W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // S1 multiply, S2 double with saturation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_sb1  <= '0;
            r_p1   <= '0;
            r_v2   <= 1'b0;
            r_sb2  <= '0;
            r_p2   <= '0;
            r_ovf2 <= 1'b0;
        end else begin
            r_v1  <= i_valid;
            r_sb1 <= i_sb;
            r_p1  <= w_prod;
            r_v2  <= r_v1;
            r_sb2 <= r_sb1;
            if (r_p1 == P_MINMIN) begin
                r_p2   <= P_MAX;
                r_ovf2 <= 1'b1;
            end else begin
                r_p2   <= {r_p1[RW-2:0], 1'b0};
                r_ovf2 <= 1'b0;
            end
        end
    end

    assign o_valid = r_v2;
    assign o_sb    = r_sb2;
    assign o_p     = r_p2;
    assign o_ovf   = r_ovf2;
endmodule

// File: rtl/lmac_pipe.sv
// Pipelined fractional multiply-accumulate with NCH saturating accumulators.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of lmac_pipe_if (ops in, results + sticky flags out)
// Latency 3, one op per cycle; S3 does the accumulator read-modify-write.
module lmac_pipe
    import lmac_pkg::*;
#(
    parameter int unsigned W   = 16,
    parameter int unsigned NCH = 4
) (
    input  logic        clk,
    input  logic        reset,
    lmac_pipe_if.slave  bus
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned RW  = 2 * W;
    localparam int unsigned SBW = 2 + CHW;

    function automatic logic signed [SAT_XW-1:0] sext(input logic [RW-1:0] v);
        return {{(SAT_XW-RW){v[RW-1]}}, v};
    endfunction

    logic             w_ch_ok;
    logic             w_v3;
    logic [SBW-1:0]   w_sb3;
    logic [RW-1:0]    w_p3;
    logic             w_movf3;
    lmac_op_e         w_op;
    logic [CHW-1:0]   w_ch;
    logic [RW-1:0]    w_acc_cur;
    logic [SAT_XW:0]  w_sat;
    logic [RW-1:0]    w_res;
    logic             w_ovf;
    logic [NCH-1:0]   w_sticky_nxt;
    logic             w_unused_sat;

    logic [RW-1:0]    r_acc [NCH];
    logic             r_out_valid;
    logic [CHW-1:0]   r_out_ch;
    logic [RW-1:0]    r_out;
    logic             r_ovf;
    logic [NCH-1:0]   r_sticky;

    // Out-of-range channels enter the pipe with valid dropped
    assign w_ch_ok = (32'(bus.in_ch) < NCH);

    frac_mult_sat #(.W(W), .SBW(SBW)) u_mult (
        .clk     (clk),
        .reset   (reset),
        .i_valid (bus.in_valid & w_ch_ok),
        .i_sb    ({bus.in_op, bus.in_ch}),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .o_valid (w_v3),
        .o_sb    (w_sb3),
        .o_p     (w_p3),
        .o_ovf   (w_movf3)
    );

    assign w_op      = lmac_op_e'(w_sb3[SBW-1:CHW]);
    assign w_ch      = w_sb3[CHW-1:0];
    assign w_acc_cur = r_acc[w_ch];
    assign w_sat     = sat_add(sext(w_acc_cur), sext(w_p3), (w_op == OP_MSU), RW);
    assign w_unused_sat = ^w_sat[SAT_XW-1:RW];

    // S3 result select and sticky update
    always_comb begin
        w_res        = '0;
        w_ovf        = 1'b0;
        w_sticky_nxt = bus.sticky_clr ? '0 : r_sticky;
        case (w_op)
            OP_MULT: begin
                w_res = w_p3;
                w_ovf = w_movf3;
            end
            OP_MAC, OP_MSU: begin
                w_res = w_sat[RW-1:0];
                w_ovf = w_movf3 | w_sat[SAT_XW];
            end
            default: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
        // A set in the same cycle as a clear wins
        if (w_v3 && w_ovf) begin
            w_sticky_nxt[w_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_sticky    <= '0;
        end else begin
            r_out_valid <= w_v3;
            r_sticky    <= w_sticky_nxt;
            if (w_v3) begin
                r_acc[w_ch] <= w_res;
                r_out_ch    <= w_ch;
                r_out       <= w_res;
                r_ovf       <= w_ovf;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_ch     = r_out_ch;
    assign bus.out        = r_out;
    assign bus.ovf        = r_ovf;
    assign bus.sticky_ovf = r_sticky;
endmodule
